// File: rtl/lasso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lasso_pkg
// Description : Shared definitions for the lasso datapath blocks (dot,
//               dot_transpose, lasso). Holds the sequencer state encoding,
//               the accumulator width rule and the fixed-point
//               shift + saturate helper that every block uses when
//               producing an N-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
package lasso_pkg;

    // Sequencer states shared by dot / dot_transpose.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A full-precision product is 2N bits. Summing ROWS of them needs
    // clog2(ROWS) guard bits, so the running sum can never wrap.
    function automatic int acc_width(input int n, input int rows);
        return 2 * n + $clog2(rows);
    endfunction

    // Convert a wide signed accumulator to an N-bit result with Q
    // fractional bits: arithmetic right shift (floor toward -inf, no
    // rounding) followed by clamping to the signed N-bit range. The return
    // value is sign-extended to 64 bits; callers keep the low N bits.
    function automatic longint sat_shift(input longint acc, input int q, input int n);
        longint shifted;
        longint hi;
        longint lo;
        shifted = acc >>> q;
        hi      = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        if (shifted > hi) begin
            return hi;
        end else if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage : lasso_pkg
`default_nettype wire

// File: rtl/fxp_mac.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mac
// Description : Registered signed multiply-accumulate.
//               Each enabled cycle adds i_a*i_b (full 2N-bit product) into a
//               wide accumulator. o_result is the saturated, Q-scaled N-bit
//               value of (accumulator + current product), so the caller can
//               capture a finished sum on the same edge that feeds the last
//               product and clears the accumulator.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous reset, active high (clears acc)
//               i_clr    - clear accumulator (priority over i_en)
//               i_en     - accumulate the current product
//               i_a,i_b  - signed N-bit operands
//               o_result - sat_shift(acc + i_a*i_b), signed N-bit
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mac
    import lasso_pkg::*;
#(
    parameter int N  = 8,
    parameter int Q  = 1,
    parameter int AW = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic signed [N-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    output logic signed [N-1:0] o_result
);

    logic signed [AW-1:0]  r_acc;
    logic signed [2*N-1:0] w_prod;
    logic signed [AW-1:0]  w_sum;
    longint                w_sat64;
    logic                  w_unused_sat;

    assign w_prod   = i_a * i_b;
    assign w_sum    = r_acc + AW'(w_prod);
    assign w_sat64  = sat_shift(64'(w_sum), Q, N);
    assign o_result = w_sat64[N-1:0];

    // Upper bits are only the sign extension of the clamped value.
    assign w_unused_sat = &{1'b0, w_sat64[63:N]};

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule : fxp_mac
`default_nettype wire

// File: rtl/dot_transpose.sv
`default_nettype none
// ============================================================================
// Module      : dot_transpose
// Description : Adjoint matrix-vector product out_C = A^T * in_B over signed
//               N-bit fixed point with Q fractional bits. One MAC per cycle,
//               column by column (row index fastest). Inputs are snapshotted
//               when start is accepted; done stays high with the result held
//               until the next accepted start.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous reset, active high
//               start - request, sampled only in IDLE or DONE
//               in_A  - matrix A [0:I-1][0:J-1], signed N-bit
//               in_B  - vector v [0:I-1], signed N-bit
//               out_C - result [0:J-1], signed N-bit, saturated
//               done  - high while out_C holds a complete result
// Revision    : 1.0 - initial release
// ============================================================================
module dot_transpose
    import lasso_pkg::*;
#(
    parameter int I = 10,
    parameter int J = 2,
    parameter int Q = 1,
    parameter int N = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [0:I-1][0:J-1][N-1:0]    in_A,
    input  logic [0:I-1][N-1:0]           in_B,
    output logic [0:J-1][N-1:0]           out_C,
    output logic                          done
);

    localparam int c_iw = (I > 1) ? $clog2(I) : 1;
    localparam int c_jw = (J > 1) ? $clog2(J) : 1;
    localparam int c_aw = acc_width(N, I);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_iw-1:0]               r_i;
    logic [c_jw-1:0]               r_j;
    logic [0:I-1][0:J-1][N-1:0]    r_a;
    logic [0:I-1][N-1:0]           r_b;

    logic                          w_accept;
    logic                          w_last_i;
    logic                          w_last_j;
    logic                          w_mac_en;
    logic                          w_mac_clr;
    logic [N-1:0]                  w_mac_result;

    assign w_last_i = (r_i == c_iw'(I - 1));
    assign w_last_j = (r_j == c_jw'(J - 1));

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mac_en    = 1'b0;
        w_mac_clr   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_mac_clr   = 1'b1;
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                // start is deliberately ignored while a computation runs.
                w_mac_en = 1'b1;
                if (w_last_i) begin
                    // The column total is taken from acc + final product,
                    // so the accumulator is free to restart next cycle.
                    w_mac_clr = 1'b1;
                    if (w_last_j) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, operand snapshot and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            out_C   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a <= in_A;
                r_b <= in_B;
                r_i <= '0;
                r_j <= '0;
            end else if (r_state == MAC) begin
                if (w_last_i) begin
                    out_C[r_j] <= w_mac_result;
                    r_i        <= '0;
                    r_j        <= w_last_j ? '0 : r_j + c_jw'(1);
                end else begin
                    r_i <= r_i + c_iw'(1);
                end
            end
        end
    end

    assign done = (r_state == DONE);

    fxp_mac #(
        .N  (N),
        .Q  (Q),
        .AW (c_aw)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_mac_clr),
        .i_en     (w_mac_en),
        .i_a      (r_a[r_i][r_j]),
        .i_b      (r_b[r_i]),
        .o_result (w_mac_result)
    );

endmodule : dot_transpose
`default_nettype wire

// File: tb/tb_dot_transpose.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_transpose
// Description : Self-checking bench for dot_transpose. A transaction-level
//               model (snapshot on accept, fixed I*J-cycle latency, result
//               from plain integer arithmetic) is compared against done and
//               out_C on every falling edge; directed cases pin the model
//               with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_transpose;

    localparam int I = 10;
    localparam int J = 2;
    localparam int Q = 1;
    localparam int N = 8;

    typedef logic [0:I-1][0:J-1][N-1:0] mat_t;
    typedef logic [0:I-1][N-1:0]        vec_t;
    typedef logic [0:J-1][N-1:0]        res_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    mat_t in_A;
    vec_t in_B;
    res_t out_C;
    logic done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_transpose #(.I(I), .J(J), .Q(Q), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_A  (in_A),
        .in_B  (in_B),
        .out_C (out_C),
        .done  (done)
    );

    // ---------------- reference arithmetic ----------------
    function automatic longint clamp_scale(input longint s);
        longint v;
        longint hi;
        v  = s >>> Q;
        hi = (64'sd1 <<< (N - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic res_t ref_adjoint(input mat_t a, input vec_t v);
        res_t r;
        for (int j = 0; j < J; j++) begin
            longint s = 0;
            for (int i = 0; i < I; i++)
                s += longint'($signed(a[i][j])) * longint'($signed(v[i]));
            r[j] = N'(clamp_scale(s));
        end
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < I; i++)
            for (int j = 0; j < J; j++)
                m[i][j] = N'($urandom);
        return m;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < I; i++) v[i] = N'($urandom);
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    logic   m_busy, m_done, m_known;
    int     m_cnt;
    res_t   m_res, m_C;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_known <= 1'b1;
            m_C     <= '0;
            m_cnt   <= 0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_known <= 1'b1;
                m_C     <= m_res;
            end
            m_cnt <= m_cnt - 1;
        end else if (start) begin
            m_res   <= ref_adjoint(in_A, in_B);
            m_cnt   <= I * J;
            m_busy  <= 1'b1;
            m_done  <= 1'b0;
            m_known <= 1'b0;
        end
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: done every cycle; out_C whenever it is defined.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("model_done", done, m_done);
            if (m_known)
                for (int j = 0; j < J; j++)
                    check("model_out_C", $signed(out_C[j]), $signed(m_C[j]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input mat_t a, input vec_t b, input int glitch_at,
                          input int mutate_at, output int lat);
        in_A  = a;
        in_B  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        check("done_low_after_accept", done, 1'b0);
        while (done !== 1'b1 && lat < 200) begin
            start = (lat == glitch_at);
            if (lat == mutate_at) begin
                in_A = rand_mat();
                in_B = rand_vec();
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, I * J);
    endtask

    task automatic check_res(input string name, input int c0, input int c1);
        check(name, $signed(out_C[0]), c0);
        check(name, $signed(out_C[1]), c1);
    endtask

    mat_t a_basic, a_sign, a_t;
    vec_t v_basic, v_two, v_t;
    int   lat;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in_A  = '0;
        in_B  = '0;
        for (int i = 0; i < I; i++) begin
            v_basic[i] = 8'd4;
            v_two[i]   = 8'd2;
            for (int j = 0; j < J; j++) a_basic[i][j] = 8'd2;
            a_sign[i][0] = N'(i);
            a_sign[i][1] = N'(-i);
        end
        repeat (3) @(negedge clk);
        check("reset_done", done, 1'b0);
        check_res("reset_out_C", 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic product: 10 * 1.0 * 2.0 = 20.0 -> 40
        run_op(a_basic, v_basic, -1, -1, lat);
        check_res("basic", 40, 40);
        repeat (4) @(negedge clk);
        check("hold_done", done, 1'b1);
        check_res("hold", 40, 40);

        // Column signs: sum(i)*2 = 90 -> 45 / -45; then restart from DONE
        run_op(a_sign, v_two, -1, -1, lat);
        check_res("sign", 45, -45);
        run_op(a_sign, v_two, -1, -1, lat);
        check_res("sign_restart", 45, -45);

        // Saturation both directions
        a_t = '0;
        v_t = '0;
        for (int i = 0; i < I; i++) begin
            v_t[i] = 8'sd127;
            for (int j = 0; j < J; j++) a_t[i][j] = 8'sd127;
        end
        run_op(a_t, v_t, -1, -1, lat);
        check_res("sat_pos", 127, 127);
        for (int i = 0; i < I; i++)
            for (int j = 0; j < J; j++) a_t[i][j] = 8'h80;
        run_op(a_t, v_t, -1, -1, lat);
        check_res("sat_neg", -128, -128);

        // Floor: 1 * -1 = -1, -1 >>> 1 = -1
        a_t = '0;
        v_t = '0;
        a_t[0][0] = 8'sd1;
        v_t[0]    = 8'hFF;
        run_op(a_t, v_t, -1, -1, lat);
        check_res("floor", -1, 0);

        // start pulse mid-computation ignored
        run_op(a_basic, v_basic, 5, -1, lat);
        check_res("start_in_mac", 40, 40);

        // Inputs changed after accept do not matter
        run_op(a_sign, v_two, -1, 3, lat);
        check_res("snapshot", 45, -45);

        // Reset mid-operation, then a fresh run
        in_A  = a_sign;
        in_B  = v_two;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_done", done, 1'b0);
        check_res("rst_mid_out_C", 0, 0);
        rst = 1'b0;
        @(negedge clk);
        run_op(a_basic, v_basic, -1, -1, lat);
        check_res("after_rst", 40, 40);

        // Adjoint consistency: sum r.(A x) == sum x.(A^T r), kept even so
        // the Q shift is exact and nothing saturates.
        for (int k = 0; k < 6; k++) begin
            int     xs[J];
            int     rs[I];
            longint lhs, rhs, s;
            for (int j = 0; j < J; j++) xs[j] = 2 * (int'($urandom_range(6)) - 3);
            for (int i = 0; i < I; i++) begin
                rs[i]  = 2 * (int'($urandom_range(2)) - 1);
                v_t[i] = N'(rs[i]);
                for (int j = 0; j < J; j++) a_t[i][j] = N'(int'($urandom_range(15)) - 8);
            end
            lhs = 0;
            for (int i = 0; i < I; i++) begin
                s = 0;
                for (int j = 0; j < J; j++) s += longint'($signed(a_t[i][j])) * xs[j];
                lhs += rs[i] * clamp_scale(s);
            end
            run_op(a_t, v_t, -1, -1, lat);
            rhs = 0;
            for (int j = 0; j < J; j++) rhs += xs[j] * longint'($signed(out_C[j]));
            check("adjoint", 32'(rhs), 32'(lhs));
        end

        // Randomized transactions with stray starts and input churn
        for (int k = 0; k < 25; k++) begin
            run_op(rand_mat(), rand_vec(), int'($urandom_range(25)),
                   int'($urandom_range(25)), lat);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dot_transpose
`default_nettype wire
